mem_access: RTL

//  MEM stage of the 5-stage MIPS pipeline; consumes the execute stage's ALU result (byte address) and rt data (store data).

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_access_load_align.sv | 28 ++
 rtl/mem_access.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: opcodes, access sizes and clear-FSM states.
package mem_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

endpackage

// File: rtl/mem_access_load_align.sv
// Load alignment: picks the byte/half lane from a memory word and sign- or zero-extends it.
module load_align
  import mem_pkg::*;
#(
  parameter int NB = 32
) (
  input  logic [NB-1:0] i_word,
  input  logic [1:0]    i_offset,
  input  size_e         i_size,
  input  logic          i_unsigned,
  output logic [NB-1:0] o_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = i_word[{i_offset, 3'b000} +: 8];
    half_v = i_word[{i_offset[1], 4'b0000} +: 16];
    o_data = i_word;
    case (i_size)
      SZ_BYTE: o_data = {{(NB-8){~i_unsigned & byte_v[7]}}, byte_v};
      SZ_HALF: o_data = {{(NB-16){~i_unsigned & half_v[15]}}, half_v};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: word-organised data memory with byte-lane stores, registered aligned loads,
// a registered debug read port and a post-reset clear sweep.
//   state    | meaning
//   ST_CLEAR | zeroing word idx_q each cycle, accesses ignored, o_ready=0
//   ST_READY | loads/stores accepted, o_ready=1
module mem_access
  import mem_pkg::*;
#(
  parameter int NB        = 32,
  parameter int NB_OPCODE = 6,
  parameter int NB_ADDR   = 10
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic [NB_OPCODE-1:0] i_op_code,
  input  logic [NB-1:0]        i_alu_result,
  input  logic [NB-1:0]        i_store_data,
  input  logic [NB_ADDR-3:0]   i_debug_addr,
  output logic                 o_ready,
  output logic [NB-1:0]        o_read_data,
  output logic                 o_read_valid,
  output logic                 o_misaligned,
  output logic [NB-1:0]        o_debug_data
);

  localparam int NW    = NB_ADDR - 2;
  localparam int DEPTH = 2 ** NW;
  localparam logic [NW-1:0] LAST_IDX = NW'(DEPTH - 1);

  state_e          state_q, state_d;
  logic [NW-1:0]   idx_q, idx_d;
  logic [NB-1:0]   read_data_q, read_data_d;
  logic            read_valid_q, read_valid_d;
  logic            misaligned_q, misaligned_d;
  logic [NB-1:0]   debug_data_q, debug_data_d;

  logic [NB-1:0]   mem [DEPTH];
  logic [3:0]      we;
  logic [NW-1:0]   wr_idx;
  logic [NB-1:0]   wr_data;

  logic [1:0]      offset;
  logic [NW-1:0]   word_idx;
  logic            is_ld, is_st, is_uns, aligned;
  logic            do_ld, do_st;
  size_e           size;
  logic [NB-1:0]   ld_data;
  logic            unused_addr_bits;

  assign offset           = i_alu_result[1:0];
  assign word_idx         = i_alu_result[NB_ADDR-1:2];
  assign unused_addr_bits = ^i_alu_result[NB-1:NB_ADDR];

  always_comb begin
    is_ld  = 1'b0;
    is_st  = 1'b0;
    is_uns = 1'b0;
    size   = SZ_WORD;
    case (i_op_code)
      OP_LB:   begin is_ld = 1'b1; size = SZ_BYTE; end
      OP_LH:   begin is_ld = 1'b1; size = SZ_HALF; end
      OP_LW:   begin is_ld = 1'b1; size = SZ_WORD; end
      OP_LBU:  begin is_ld = 1'b1; size = SZ_BYTE; is_uns = 1'b1; end
      OP_LHU:  begin is_ld = 1'b1; size = SZ_HALF; is_uns = 1'b1; end
      OP_SB:   begin is_st = 1'b1; size = SZ_BYTE; end
      OP_SH:   begin is_st = 1'b1; size = SZ_HALF; end
      OP_SW:   begin is_st = 1'b1; size = SZ_WORD; end
      default: ;
    endcase
  end

  always_comb begin
    case (size)
      SZ_BYTE: aligned = 1'b1;
      SZ_HALF: aligned = ~offset[0];
      default: aligned = (offset == 2'b00);
    endcase
  end

  // A store with the read flag also set still counts as a store; the read is dropped.
  assign do_st = (state_q == ST_READY) & i_valid & i_mem_write & is_st;
  assign do_ld = (state_q == ST_READY) & i_valid & i_mem_read & ~i_mem_write & is_ld;

  load_align #(.NB(NB)) u_load_align (
    .i_word     (mem[word_idx]),
    .i_offset   (offset),
    .i_size     (size),
    .i_unsigned (is_uns),
    .o_data     (ld_data)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    we           = 4'b0000;
    wr_idx       = word_idx;
    wr_data      = i_store_data;
    read_valid_d = do_ld & aligned;
    misaligned_d = (do_ld | do_st) & ~aligned;
    read_data_d  = read_data_q;
    debug_data_d = mem[i_debug_addr];

    if (state_q == ST_CLEAR) begin
      we      = 4'b1111;
      wr_idx  = idx_q;
      wr_data = '0;
      idx_d   = idx_q + 1'b1;
      if (idx_q == LAST_IDX) state_d = ST_READY;
    end else if (do_st & aligned) begin
      case (size)
        SZ_BYTE: begin we = 4'b0001 << offset; wr_data = {(NB/8){i_store_data[7:0]}}; end
        SZ_HALF: begin we = offset[1] ? 4'b1100 : 4'b0011; wr_data = {(NB/16){i_store_data[15:0]}}; end
        default: we = 4'b1111;
      endcase
    end

    if (misaligned_d) read_data_d = '0;
    else if (read_valid_d) read_data_d = ld_data;
  end

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b] & ~i_reset) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_CLEAR;
      idx_q        <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      debug_data_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      misaligned_q <= misaligned_d;
      debug_data_q <= debug_data_d;
    end
  end

  assign o_ready      = (state_q == ST_READY);
  assign o_read_data  = read_data_q;
  assign o_read_valid = read_valid_q;
  assign o_misaligned = misaligned_q;
  assign o_debug_data = debug_data_q;

endmodule
